// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RISC-V load/store
// func3 encodings, the responder state type and latency limits.
// Optional feature macro used elsewhere in this slice: DMEM_MISALIGN_CHK_EN.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);
    localparam int WORD_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data-memory responder.
// Builds the store byte-enable and replicated write word, and extracts and
// sign/zero-extends the load result from the addressed word.
// With DMEM_MISALIGN_CHK_EN defined, misaligned halfword/word accesses are
// flagged, suppress the store and force the load result to zero; otherwise
// word accesses ignore address[1:0] and halfword accesses ignore address[0].
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]        func3_i,
    input  logic [1:0]        addrLow_i,
    input  logic [WORD_W-1:0] storeData_i,
    input  logic [WORD_W-1:0] readWord_i,
    output logic [3:0]        byteEn_o,
    output logic [WORD_W-1:0] writeWord_o,
    output logic [WORD_W-1:0] loadData_o
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    input  logic              isStore_i,
    output logic              misaligned_o
`endif
);

    logic        misAlign;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Decide whether the access straddles its natural alignment boundary.
    always_comb begin
        misAlign = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
        case (func3_i)
            F3_H:    misAlign = addrLow_i[0];
            F3_HU:   misAlign = !isStore_i && addrLow_i[0];
            F3_W:    misAlign = |addrLow_i;
            default: misAlign = 1'b0;
        endcase
`endif
    end

`ifdef DMEM_MISALIGN_CHK_EN
    assign misaligned_o = misAlign;
`endif

    // Pick the addressed byte and halfword out of the stored word.
    always_comb begin
        byteSel = readWord_i[7:0];
        case (addrLow_i)
            2'd0:    byteSel = readWord_i[7:0];
            2'd1:    byteSel = readWord_i[15:8];
            2'd2:    byteSel = readWord_i[23:16];
            default: byteSel = readWord_i[31:24];
        endcase
        halfSel = addrLow_i[1] ? readWord_i[31:16] : readWord_i[15:0];
    end

    // Extend the selected lane into the right-aligned load result.
    always_comb begin
        loadData_o = '0;
        case (func3_i)
            F3_B:    loadData_o = {{24{byteSel[7]}}, byteSel};
            F3_H:    loadData_o = {{16{halfSel[15]}}, halfSel};
            F3_W:    loadData_o = readWord_i;
            F3_BU:   loadData_o = {24'h0, byteSel};
            F3_HU:   loadData_o = {16'h0, halfSel};
            default: loadData_o = '0;
        endcase
        if (misAlign) begin
            loadData_o = '0;
        end
    end

    // Replicate store data across lanes and enable only the addressed ones.
    always_comb begin
        byteEn_o    = 4'b0000;
        writeWord_o = '0;
        case (func3_i)
            F3_B: begin
                byteEn_o    = 4'b0001 << addrLow_i;
                writeWord_o = {4{storeData_i[7:0]}};
            end
            F3_H: begin
                byteEn_o    = addrLow_i[1] ? 4'b1100 : 4'b0011;
                writeWord_o = {2{storeData_i[15:0]}};
            end
            F3_W: begin
                byteEn_o    = 4'b1111;
                writeWord_o = storeData_i;
            end
            default: begin
                byteEn_o    = 4'b0000;
                writeWord_o = '0;
            end
        endcase
        if (misAlign) begin
            byteEn_o = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port.
// Accepts one request at a time, waits LATENCY cycles, commits the store or
// registers the load result on the edge into RESP and pulses ready once.
// Optional feature macro: DMEM_MISALIGN_CHK_EN adds the misaligned output.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEMORY_DEPTH  = 4096,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read_En,
    input  logic                     write_En,
    input  logic [2:0]               func3,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     ready
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic                     misaligned
`endif
);

    localparam int IDX_W  = $clog2(MEMORY_DEPTH);
    localparam int KEEP_W = IDX_W + 2;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    isWrite_q, isWrite_d;
    logic                    isRead_q, isRead_d;
    logic [2:0]              func3_q, func3_d;
    logic [KEEP_W-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   dataOut_q;

    logic                    enterResp;
    logic                    reqWrite;
    logic                    reqRead;
    logic [2:0]              reqFunc3;
    logic [KEEP_W-1:0]       reqAddr;
    logic [DATA_WIDTH-1:0]   reqData;
    logic [IDX_W-1:0]        reqIdx;

    logic [DATA_WIDTH-1:0]   readWord;
    logic [3:0]              byteEn;
    logic [DATA_WIDTH-1:0]   writeWord;
    logic [DATA_WIDTH-1:0]   loadData;

    logic [DATA_WIDTH-1:0]   mem [MEMORY_DEPTH];

    logic                    unusedAddressBits;
    assign unusedAddressBits = ^address[ADDRESS_WIDTH-1:KEEP_W];

`ifdef DMEM_MISALIGN_CHK_EN
    logic misAlign;
    logic misaligned_q;
`endif

    // With LATENCY=1 the commit happens straight from IDLE, so the live
    // inputs are used there; every other state works from the captured copy.
    always_comb begin
        if (state_q == IDLE) begin
            reqWrite = write_En;
            reqRead  = read_En && !write_En;
            reqFunc3 = func3;
            reqAddr  = address[KEEP_W-1:0];
            reqData  = data_in;
        end else begin
            reqWrite = isWrite_q;
            reqRead  = isRead_q;
            reqFunc3 = func3_q;
            reqAddr  = addr_q;
            reqData  = wdata_q;
        end
    end

    assign reqIdx   = reqAddr[KEEP_W-1:2];
    assign readWord = mem[reqIdx];

    dmem_lane_align u_align (
        .func3_i     (reqFunc3),
        .addrLow_i   (reqAddr[1:0]),
        .storeData_i (reqData),
        .readWord_i  (readWord),
        .byteEn_o    (byteEn),
        .writeWord_o (writeWord),
        .loadData_o  (loadData)
`ifdef DMEM_MISALIGN_CHK_EN
        ,
        .isStore_i    (reqWrite),
        .misaligned_o (misAlign)
`endif
    );

    // Next-state logic: capture in IDLE, count down in WAIT, one cycle of RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isWrite_d = isWrite_q;
        isRead_d  = isRead_q;
        func3_d   = func3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        enterResp = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_En || write_En) begin
                    isWrite_d = write_En;
                    isRead_d  = read_En && !write_En;
                    func3_d   = func3;
                    addr_d    = address[KEEP_W-1:0];
                    wdata_d   = data_in;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d   = RESP;
                        enterResp = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d     = '0;
                    state_d   = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, wait counter and captured request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isWrite_q <= 1'b0;
            isRead_q  <= 1'b0;
            func3_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isWrite_q <= isWrite_d;
            isRead_q  <= isRead_d;
            func3_q   <= func3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Stores land only on the edge into RESP and never while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && reqWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[reqIdx][8*b +: 8] <= writeWord[8*b +: 8];
                end
            end
        end
    end

    // Load result is registered alongside the move into RESP and then held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut_q <= '0;
        end else if (enterResp) begin
            dataOut_q <= reqRead ? loadData : '0;
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    // Misalignment flag travels with the ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= enterResp && misAlign;
        end
    end

    assign misaligned = misaligned_q;
`endif

    assign ready    = (state_q == RESP);
    assign data_out = dataOut_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=2 and full
// depth, one with LATENCY=1 and a 16-word array for address aliasing.
// Define DMEM_MISALIGN_CHK_EN to exercise the misalignment flag as well.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic        rdA, wrA, readyA;
    logic [2:0]  f3A;
    logic [31:0] addrA, dinA, doutA;
    logic        rdB, wrB, readyB;
    logic [2:0]  f3B;
    logic [31:0] addrB, dinB, doutB;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        misA, misB;
`endif

    int checkCount = 0;
    int failCount  = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    dmem_responder #(
        .MEMORY_DEPTH  (4096),
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .LATENCY       (2)
    ) dutA (
        .clk      (clk),
        .rst      (rst),
        .read_En  (rdA),
        .write_En (wrA),
        .func3    (f3A),
        .address  (addrA),
        .data_in  (dinA),
        .data_out (doutA),
        .ready    (readyA)
`ifdef DMEM_MISALIGN_CHK_EN
        ,
        .misaligned (misA)
`endif
    );

    dmem_responder #(
        .MEMORY_DEPTH  (16),
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .LATENCY       (1)
    ) dutB (
        .clk      (clk),
        .rst      (rst),
        .read_En  (rdB),
        .write_En (wrB),
        .func3    (f3B),
        .address  (addrB),
        .data_in  (dinB),
        .data_out (doutB),
        .ready    (readyB)
`ifdef DMEM_MISALIGN_CHK_EN
        ,
        .misaligned (misB)
`endif
    );

    // Count one comparison and report it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Drive the request inputs of the selected instance.
    task automatic driveReq(input bit useB, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data);
        if (useB) begin
            rdB = rd; wrB = wr; f3B = f3; addrB = addr; dinB = data;
        end else begin
            rdA = rd; wrA = wr; f3A = f3; addrA = addr; dinA = data;
        end
    endtask

    // Present a request (called at a falling edge), hold it until ready is
    // seen, keep it over the RESP edge, then check ready dropped and release.
    task automatic applyStimulus(input bit useB, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, output int latency,
                                 output logic [31:0] dout
`ifdef DMEM_MISALIGN_CHK_EN
                                 , output logic mis
`endif
                                 );
        logic rdy;
        latency = -1;
        dout    = 'x;
`ifdef DMEM_MISALIGN_CHK_EN
        mis     = 1'b0;
`endif
        driveReq(useB, rd, wr, f3, addr, data);
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            rdy = useB ? readyB : readyA;
            if (rdy) begin
                latency = i;
                dout    = useB ? doutB : doutA;
`ifdef DMEM_MISALIGN_CHK_EN
                mis     = useB ? misB : misA;
`endif
                break;
            end
        end
        @(negedge clk);
        rdy = useB ? readyB : readyA;
        checkOutput("readyPulse", {31'b0, rdy}, 32'h0);
        driveReq(useB, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Run one access and compare its latency and, for loads, its data.
    task automatic checkAccess(input string tag, input bit useB, input logic rd,
                               input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int expLat, input bit checkData,
                               input logic [31:0] expData);
        int          lat;
        logic [31:0] dout;
`ifdef DMEM_MISALIGN_CHK_EN
        logic        mis;
        applyStimulus(useB, rd, wr, f3, addr, data, lat, dout, mis);
        checkOutput({tag, "_mis"}, {31'b0, mis}, 32'h0);
`else
        applyStimulus(useB, rd, wr, f3, addr, data, lat, dout);
`endif
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
        if (checkData) begin
            checkOutput({tag, "_data"}, dout, expData);
        end
    endtask

    // Abort guard so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        bit sawReady;
        rst = 1'b1;
        driveReq(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        driveReq(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rstReadyA", {31'b0, readyA}, 32'h0);
        checkOutput("rstDoutA",  doutA,           32'h0);
        checkOutput("rstReadyB", {31'b0, readyB}, 32'h0);
        checkOutput("rstDoutB",  doutB,           32'h0);
        rst = 1'b0;
        @(negedge clk);

        // LATENCY=2: word store/load, then lane extraction.
        checkAccess("swDeadbeef", 1'b0, 1'b0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        checkAccess("lw10",       1'b0, 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 2, 1'b1, 32'hDEADBEEF);
        checkAccess("lb13",       1'b0, 1'b1, 1'b0, F3_B,  32'h13, 32'h0, 2, 1'b1, 32'hFFFFFFDE);
        checkAccess("lbu13",      1'b0, 1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 2, 1'b1, 32'h000000DE);
        checkAccess("lh12",       1'b0, 1'b1, 1'b0, F3_H,  32'h12, 32'h0, 2, 1'b1, 32'hFFFFDEAD);
        checkAccess("lhu10",      1'b0, 1'b1, 1'b0, F3_HU, 32'h10, 32'h0, 2, 1'b1, 32'h0000BEEF);
        checkAccess("lb10",       1'b0, 1'b1, 1'b0, F3_B,  32'h10, 32'h0, 2, 1'b1, 32'hFFFFFFEF);

        // Partial stores leave the other lanes untouched.
        checkAccess("sb11",       1'b0, 1'b0, 1'b1, F3_B,  32'h11, 32'h12345677, 2, 1'b0, 32'h0);
        checkAccess("lwAfterSb",  1'b0, 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 2, 1'b1, 32'hDEAD77EF);
        checkAccess("sh12",       1'b0, 1'b0, 1'b1, F3_H,  32'h12, 32'hAAAA5555, 2, 1'b0, 32'h0);
        checkAccess("lwAfterSh",  1'b0, 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 2, 1'b1, 32'h555577EF);

        // Unsupported codes still pulse ready but neither read nor write.
        checkAccess("lBadF3",     1'b0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 2, 1'b1, 32'h0);
        checkAccess("sBadF3",     1'b0, 1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 2, 1'b0, 32'h0);
        checkAccess("lwAfterBad", 1'b0, 1'b1, 1'b0, F3_W,   32'h10, 32'h0, 2, 1'b1, 32'h555577EF);

        // Read and write together behave as a write with a zero result.
        checkAccess("rdWrBoth",   1'b0, 1'b1, 1'b1, F3_W,  32'h14, 32'hCAFEF00D, 2, 1'b1, 32'h0);
        checkAccess("lw14",       1'b0, 1'b1, 1'b0, F3_W,  32'h14, 32'h0, 2, 1'b1, 32'hCAFEF00D);

        // Reset during WAIT drops the pending store.
        checkAccess("sw20zero",   1'b0, 1'b0, 1'b1, F3_W,  32'h20, 32'h0, 2, 1'b0, 32'h0);
        driveReq(1'b0, 1'b0, 1'b1, F3_W, 32'h20, 32'h1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("waitReady", {31'b0, readyA}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("midRstReady", {31'b0, readyA}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        driveReq(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        sawReady = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sawReady = sawReady | readyA;
        end
        checkOutput("noReadyAfterRst", {31'b0, sawReady}, 32'h0);
        checkAccess("lw20AfterRst", 1'b0, 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 2, 1'b1, 32'h0);

        // LATENCY=1 back-to-back with address aliasing on a 16-word array.
        checkAccess("bSw50",      1'b1, 1'b0, 1'b1, F3_W,  32'h50, 32'h11223344, 1, 1'b0, 32'h0);
        checkAccess("bLw10",      1'b1, 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 1, 1'b1, 32'h11223344);
        checkAccess("bLh52",      1'b1, 1'b1, 1'b0, F3_H,  32'h52, 32'h0, 1, 1'b1, 32'h00001122);
        checkAccess("bLb10",      1'b1, 1'b1, 1'b0, F3_B,  32'h10, 32'h0, 1, 1'b1, 32'h00000044);

`ifdef DMEM_MISALIGN_CHK_EN
        begin
            int          lat;
            logic [31:0] dout;
            logic        mis;
            applyStimulus(1'b0, 1'b0, 1'b1, F3_W, 32'h22, 32'hFFFFFFFF, lat, dout, mis);
            checkOutput("misSwLat", 32'(lat), 32'd2);
            checkOutput("misSwFlag", {31'b0, mis}, 32'h1);
            applyStimulus(1'b0, 1'b1, 1'b0, F3_W, 32'h20, 32'h0, lat, dout, mis);
            checkOutput("misLw20Data", dout, 32'h0);
            checkOutput("misLw20Flag", {31'b0, mis}, 32'h0);
            applyStimulus(1'b0, 1'b1, 1'b0, F3_W, 32'h21, 32'h0, lat, dout, mis);
            checkOutput("misLw21Data", dout, 32'h0);
            checkOutput("misLw21Flag", {31'b0, mis}, 32'h1);
            applyStimulus(1'b0, 1'b1, 1'b0, F3_HU, 32'h13, 32'h0, lat, dout, mis);
            checkOutput("misLhuFlag", {31'b0, mis}, 32'h1);
        end
`else
        checkAccess("bLw13Align", 1'b1, 1'b1, 1'b0, F3_W,  32'h13, 32'h0, 1, 1'b1, 32'h11223344);
        checkAccess("bLhu53",     1'b1, 1'b1, 1'b0, F3_HU, 32'h53, 32'h0, 1, 1'b1, 32'h00001122);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
